// File: rtl/epp_host_if.sv
// -----------------------------------------------------------------------------
// epp_host_if
// Signal bundle between the EPP host engine and its surroundings: the
// command/response handshake on one side and the EPP bus pins on the other.
//
//   cmd_valid/cmd_ready    request handshake (accept when both high)
//   cmd_addr               1 = address cycle (Astb), 0 = data cycle (Dstb)
//   cmd_write              1 = write, 0 = read
//   cmd_wdata[7:0]         write byte
//   rsp_valid              one-cycle pulse, transfer finished
//   rsp_rdata[7:0]         read byte (0x00 after writes and aborts)
//   rsp_error              transfer aborted by timeout
//   epp_db_out[7:0]        DB value driven by the host
//   epp_db_oe              host drives DB (tristate enable at top level)
//   epp_db_in[7:0]         DB value seen at the pin
//   epp_astb/epp_dstb      address/data strobes, active low
//   epp_wr                 0 = write, 1 = read
//   epp_wait               peripheral Wait, asynchronous
//
// Modports:
//   master - the host engine (drives strobes, DB and the response)
//   slave  - everything else (command source plus EPP peripheral)
// -----------------------------------------------------------------------------
interface epp_host_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_addr;
  logic       cmd_write;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic [7:0] epp_db_out;
  logic       epp_db_oe;
  logic [7:0] epp_db_in;
  logic       epp_astb;
  logic       epp_dstb;
  logic       epp_wr;
  logic       epp_wait;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, epp_db_in, epp_wait,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           epp_db_out, epp_db_oe, epp_astb, epp_dstb, epp_wr
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, epp_db_in, epp_wait,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
           epp_db_out, epp_db_oe, epp_astb, epp_dstb, epp_wr
  );
endinterface

// File: rtl/epp_host.sv
// -----------------------------------------------------------------------------
// epp_host
// EPP host (initiator) engine. Turns single address/data read/write requests
// into EPP bus cycles (Astb/Dstb/Wr strobes, DB drive, Wait handshake) and
// reports completion on a one-cycle response strobe.
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   epp_host_if.master (command, response and EPP pin signals)
//
// Parameters:
//   SETUP_CYCLES    clk cycles Wr/DB are stable before the strobe falls (1-15)
//   TIMEOUT_CYCLES  clk cycles per handshake phase before abort (2-65535),
//                   only meaningful when EPP_HOST_TIMEOUT_EN is defined
//
// Optional feature macro: EPP_HOST_TIMEOUT_EN
//   defined     -> a 16-bit watchdog aborts a stuck STROBE/RELEASE phase and
//                  answers with rsp_error = 1
//   not defined -> phases wait indefinitely, rsp_error is always 0
// -----------------------------------------------------------------------------
module epp_host #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  epp_host_if.master bus
);

  // Reject out-of-range configurations at elaboration time.
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("epp_host: SETUP_CYCLES must be 1..15");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("epp_host: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  state_e     state_q,     state_d;
  logic [3:0] setup_cnt_q, setup_cnt_d;
  logic       is_addr_q,   is_addr_d;
  logic       is_write_q,  is_write_d;
  logic [7:0] rd_q,        rd_d;
  logic       astb_q,      astb_d;
  logic       dstb_q,      dstb_d;
  logic       wr_q,        wr_d;
  logic [7:0] db_out_q,    db_out_d;
  logic       db_oe_q,     db_oe_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_error_q, rsp_error_d;
  logic       wait_meta_q;
  logic       wait_s_q;
  logic       cmd_ready_s;
`ifdef EPP_HOST_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
`endif

  // Wait synchronizer; comes out of reset as "busy" so that no cycle starts
  // before the real pin level has been observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_meta_q <= 1'b1;
      wait_s_q    <= 1'b1;
    end else begin
      wait_meta_q <= bus.epp_wait;
      wait_s_q    <= wait_meta_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= 4'd0;
      is_addr_q   <= 1'b0;
      is_write_q  <= 1'b0;
      rd_q        <= 8'h00;
      astb_q      <= 1'b1;
      dstb_q      <= 1'b1;
      wr_q        <= 1'b1;
      db_out_q    <= 8'h00;
      db_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_error_q <= 1'b0;
`ifdef EPP_HOST_TIMEOUT_EN
      to_cnt_q    <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      is_addr_q   <= is_addr_d;
      is_write_q  <= is_write_d;
      rd_q        <= rd_d;
      astb_q      <= astb_d;
      dstb_q      <= dstb_d;
      wr_q        <= wr_d;
      db_out_q    <= db_out_d;
      db_oe_q     <= db_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
`ifdef EPP_HOST_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Next-state and next-output logic of the bus-cycle sequencer.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    is_addr_d   = is_addr_q;
    is_write_d  = is_write_q;
    rd_d        = rd_q;
    astb_d      = astb_q;
    dstb_d      = dstb_q;
    wr_d        = wr_q;
    db_out_d    = db_out_q;
    db_oe_d     = db_oe_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    cmd_ready_s = 1'b0;
`ifdef EPP_HOST_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Never start while the previous peripheral still holds Wait.
        cmd_ready_s = ~wait_s_q;
        if (bus.cmd_valid && cmd_ready_s) begin
          is_addr_d   = bus.cmd_addr;
          is_write_d  = bus.cmd_write;
          wr_d        = ~bus.cmd_write;
          setup_cnt_d = 4'd0;
          state_d     = ST_SETUP;
          if (bus.cmd_write) begin
            db_out_d = bus.cmd_wdata;
            db_oe_d  = 1'b1;
          end else begin
            db_oe_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          if (is_addr_q) begin
            astb_d = 1'b0;
          end else begin
            dstb_d = 1'b0;
          end
          state_d = ST_STROBE;
`ifdef EPP_HOST_TIMEOUT_EN
          to_cnt_d = 16'd0;
`endif
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end

      ST_STROBE: begin
        // A Wait already high on entry is taken as the handshake.
        if (wait_s_q) begin
          if (!is_write_q) begin
            rd_d = bus.epp_db_in;
          end else begin
            rd_d = rd_q;
          end
          astb_d  = 1'b1;
          dstb_d  = 1'b1;
          state_d = ST_RELEASE;
`ifdef EPP_HOST_TIMEOUT_EN
          to_cnt_d = 16'd0;
        end else if (to_cnt_q == TO_LAST) begin
          astb_d      = 1'b1;
          dstb_d      = 1'b1;
          db_oe_d     = 1'b0;
          wr_d        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = 8'h00;
          state_d     = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`else
        end else begin
          state_d = ST_STROBE;
        end
`endif
      end

      ST_RELEASE: begin
        // DB and Wr stay put until the peripheral has dropped Wait.
        if (!wait_s_q) begin
          db_oe_d     = 1'b0;
          wr_d        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          state_d     = ST_IDLE;
          if (is_write_q) begin
            rsp_rdata_d = 8'h00;
          end else begin
            rsp_rdata_d = rd_q;
          end
`ifdef EPP_HOST_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          db_oe_d     = 1'b0;
          wr_d        = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = 8'h00;
          state_d     = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`else
        end else begin
          state_d = ST_RELEASE;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready  = cmd_ready_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.epp_db_out = db_out_q;
  assign bus.epp_db_oe  = db_oe_q;
  assign bus.epp_astb   = astb_q;
  assign bus.epp_dstb   = dstb_q;
  assign bus.epp_wr     = wr_q;

endmodule

// File: tb/tb_epp_host.sv
// -----------------------------------------------------------------------------
// tb_epp_host
// Self-checking bench for epp_host: a clocked EPP peripheral model with
// programmable Wait delays (or a zero-delay combinational Wait), a bus monitor
// that records strobe pulses, and transaction-level expectations.
// -----------------------------------------------------------------------------
module tb_epp_host;
  localparam int SETUP = 2;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  epp_host_if bus();

  epp_host #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- peripheral model ----------------
  bit         comb_mode   = 1'b0;
  bit         never_raise = 1'b0;
  int         rise_dly    = 3;
  int         fall_dly    = 3;
  logic [7:0] per_rdata   = 8'h00;
  logic       wait_reg    = 1'b0;
  int         lo_cnt      = 0;
  int         hi_cnt      = 0;

  assign bus.epp_wait  = comb_mode ? ~(bus.epp_astb & bus.epp_dstb) : wait_reg;
  assign bus.epp_db_in = per_rdata;

  always @(posedge clk) begin
    if (never_raise) begin
      wait_reg <= 1'b0;
      lo_cnt   <= 0;
      hi_cnt   <= 0;
    end else if (!(bus.epp_astb && bus.epp_dstb)) begin
      hi_cnt <= 0;
      if (!wait_reg) begin
        if (lo_cnt + 1 >= rise_dly) wait_reg <= 1'b1;
        lo_cnt <= lo_cnt + 1;
      end
    end else begin
      lo_cnt <= 0;
      if (wait_reg) begin
        if (hi_cnt + 1 >= fall_dly) wait_reg <= 1'b0;
        hi_cnt <= hi_cnt + 1;
      end else begin
        hi_cnt <= 0;
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct packed {
    logic       is_addr;
    logic       wr;
    logic       oe;
    logic [7:0] db;
    logic [7:0] stable;
  } stb_ev_t;

  stb_ev_t stb_q[$];
  int   cyc = 0;
  int   stable_run = 0, low_len = 0, last_low_len = 0;
  int   both_low_viol = 0, ready_viol = 0, rsp_cnt = 0;
  logic bs1 = 1'b0, bs2 = 1'b0;
  logic [9:0] prev_sig = 10'd0;
  bit   prev_low = 1'b0;

  wire [9:0] mon_sig = {bus.epp_wr, bus.epp_db_oe, bus.epp_db_out};
  wire       mon_low = ~(bus.epp_astb & bus.epp_dstb);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bs1 <= bus.epp_wait;
    bs2 <= bs1;
  end

  always @(negedge clk) begin
    if (!bus.epp_astb && !bus.epp_dstb) both_low_viol <= both_low_viol + 1;
    if (bs2 && bus.cmd_ready) ready_viol <= ready_viol + 1;
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (mon_low) begin
      if (!prev_low) begin
        stb_q.push_back({~bus.epp_astb, bus.epp_wr, bus.epp_db_oe, bus.epp_db_out, stable_run[7:0]});
        low_len <= 1;
      end else begin
        low_len <= low_len + 1;
      end
    end else begin
      if (prev_low) last_low_len <= low_len;
      low_len    <= 0;
      stable_run <= (mon_sig == prev_sig) ? stable_run + 1 : 1;
    end
    prev_sig <= mon_sig;
    prev_low <= mon_low;
  end

  // ---------------- helpers ----------------
  task automatic issue(input bit a, input bit w, input logic [7:0] wd, output bit accepted);
    accepted = 1'b0;
    @(posedge clk); #1;
    bus.cmd_addr  = a;
    bus.cmd_write = w;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wdata = 8'($urandom);
  endtask

  task automatic xfer(input bit a, input bit w, input logic [7:0] wd, input logic [7:0] prd);
    bit got;
    int acc_edge, base, lat;
    logic last_oe;
    stb_ev_t ev;
    per_rdata = prd;
    stb_q.delete();
    base = rsp_cnt;
    issue(a, w, wd, got);
    acc_edge = cyc;
    check("accepted", got, 1);
    if (!got) return;
    got = 1'b0;
    last_oe = bus.epp_db_oe;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      last_oe = bus.epp_db_oe;
    end
    check("rsp_seen", got, 1);
    if (!got) return;
    lat = cyc - acc_edge;
    check("rsp_rdata", bus.rsp_rdata, w ? 8'h00 : prd);
    check("rsp_error", bus.rsp_error, 0);
    check("db_held_release", last_oe, w);
    check("wr_released", bus.epp_wr, 1);
    check("oe_released", bus.epp_db_oe, 0);
    if (comb_mode) check("latency", lat, SETUP + 6);
    @(negedge clk);
    check("rsp_one_cycle", bus.rsp_valid, 0);
    check("rsp_count", rsp_cnt - base, 1);
    check("strobe_count", stb_q.size(), 1);
    if (stb_q.size() > 0) begin
      ev = stb_q.pop_front();
      check("strobe_kind", ev.is_addr, a);
      check("wr_level", ev.wr, !w);
      check("db_oe", ev.oe, w);
      if (w) check("db_value", ev.db, wd);
      check("setup_hold", ev.stable >= 8'(SETUP), 1);
    end
  endtask

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    int base, k;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_astb", bus.epp_astb, 1);
    check("rst_dstb", bus.epp_dstb, 1);
    check("rst_wr", bus.epp_wr, 1);
    check("rst_oe", bus.epp_db_oe, 0);
    check("rst_db", bus.epp_db_out, 8'h00);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
    check("rst_rsp_error", bus.rsp_error, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: data write 0xA5, then address read 0x3C.
    rise_dly = 3; fall_dly = 3;
    xfer(1'b0, 1'b1, 8'hA5, 8'h00);
    xfer(1'b1, 1'b0, 8'h00, 8'h3C);

    // Random transfers against a slow peripheral.
    for (int n = 0; n < 20; n++) begin
      rise_dly = $urandom_range(1, 4);
      fall_dly = $urandom_range(1, 4);
      xfer(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end

    // Zero-delay peripheral: latency is fixed.
    comb_mode = 1'b1;
    xfer(1'b0, 1'b1, 8'h5C, 8'h00);
    xfer(1'b1, 1'b0, 8'h00, 8'hC3);
    for (int n = 0; n < 8; n++) begin
      xfer(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    end
    comb_mode = 1'b0;

    // Back-to-back data writes 0x01..0x04 with cmd_valid held.
    rise_dly = 2; fall_dly = 2;
    stb_q.delete();
    base = rsp_cnt;
    k = 0;
    @(posedge clk); #1;
    bus.cmd_addr  = 1'b0;
    bus.cmd_write = 1'b1;
    bus.cmd_wdata = 8'h01;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 400 && k < 4; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk); #1;
        k++;
        if (k < 4) bus.cmd_wdata = 8'(k + 1);
        else       bus.cmd_valid = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    check("b2b_accepts", k, 4);
    for (int i = 0; i < 100 && (rsp_cnt - base) < 4; i++) @(negedge clk);
    @(negedge clk);
    check("b2b_rsp_count", rsp_cnt - base, 4);
    check("b2b_strobes", stb_q.size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < stb_q.size()) begin
        check($sformatf("b2b_db%0d", j), stb_q[j].db, j + 1);
        check($sformatf("b2b_dstb%0d", j), stb_q[j].is_addr, 0);
      end
    end

    // Reset while Dstb is low.
    rise_dly = 1; fall_dly = 3;
    base = rsp_cnt;
    issue(1'b0, 1'b1, 8'h5A, got);
    check("rst_accepted", got, 1);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.epp_dstb) begin
        got = 1'b1;
        break;
      end
    end
    check("rst_reached_strobe", got, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_dstb", bus.epp_dstb, 1);
    check("rst_mid_oe", bus.epp_db_oe, 0);
    check("rst_mid_rsp", bus.rsp_valid, 0);
    check("rst_mid_ready", bus.cmd_ready, 0);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1'b1;
        check("rst_ready_after_wait", bus.epp_wait, 0);
        break;
      end
    end
    check("rst_ready_seen", got, 1);
    repeat (5) @(negedge clk);
    check("rst_no_rsp", rsp_cnt - base, 0);

    // Peripheral that never answers.
    never_raise = 1'b1;
    base = rsp_cnt;
    issue(1'b0, 1'b1, 8'h77, got);
    check("to_accepted", got, 1);
`ifdef EPP_HOST_TIMEOUT_EN
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("to_rsp_seen", got, 1);
    check("to_error", bus.rsp_error, 1);
    check("to_rdata", bus.rsp_rdata, 8'h00);
    check("to_dstb", bus.epp_dstb, 1);
    check("to_oe", bus.epp_db_oe, 0);
    check("to_wr", bus.epp_wr, 1);
    @(negedge clk);
    check("to_dstb_low_len", last_low_len, TMO);
    check("to_rsp_count", rsp_cnt - base, 1);
`else
    repeat (1000) @(negedge clk);
    check("no_to_rsp", rsp_cnt - base, 0);
    check("no_to_dstb_held", bus.epp_dstb, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("no_to_recover_dstb", bus.epp_dstb, 1);
`endif
    never_raise = 1'b0;
    repeat (5) @(negedge clk);

    check("both_strobes_low", both_low_viol, 0);
    check("ready_while_wait", ready_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
